// File: rtl/parity_frame_rx.sv
// Serial frame receiver: start / DATA_W data bits (LSB first) / even parity / stop.
// Reports each frame as good, parity-bad or framing-bad with a one-cycle pulse.
module parity_frame_rx #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx,
  output logic [DATA_W-1:0] data,
  output logic              valid,
  output logic              parity_err,
  output logic              frame_err,
  output logic              busy
);

  localparam int H  = CLKS_PER_BIT / 2;
  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam int IW = $clog2(DATA_W + 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(H - 1);
  localparam logic [CW-1:0] CNT_BIT  = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_W - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    PARITY    = 3'd3,
    STOP      = 3'd4,
    WAIT_IDLE = 3'd5
  } state_t;

  state_t            state, state_n;
  logic [1:0]        sync;
  logic              rx_s;
  logic [CW-1:0]     cnt, cnt_n;
  logic [IW-1:0]     idx, idx_n;
  logic              par, par_n;
  logic              p_bit, p_bit_n;
  logic [DATA_W-1:0] shreg, shreg_n;
  logic [DATA_W-1:0] data_n;
  logic              valid_n, parity_err_n, frame_err_n, busy_n;

  assign rx_s = sync[1];

  // Two-flop synchronizer for the asynchronous serial line
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync <= 2'b11;
    end else begin
      sync <= {sync[0], rx};
    end
  end

  // State, counters, datapath and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      idx        <= '0;
      par        <= 1'b0;
      p_bit      <= 1'b0;
      shreg      <= '0;
      data       <= '0;
      valid      <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      idx        <= idx_n;
      par        <= par_n;
      p_bit      <= p_bit_n;
      shreg      <= shreg_n;
      data       <= data_n;
      valid      <= valid_n;
      parity_err <= parity_err_n;
      frame_err  <= frame_err_n;
      busy       <= busy_n;
    end
  end

  // Next-state and next-output logic; every sample point restarts cnt
  always_comb begin
    state_n      = state;
    cnt_n        = cnt + 1'b1;
    idx_n        = idx;
    par_n        = par;
    p_bit_n      = p_bit;
    shreg_n      = shreg;
    data_n       = data;
    valid_n      = 1'b0;
    parity_err_n = 1'b0;
    frame_err_n  = 1'b0;

    case (state)
      IDLE: begin
        cnt_n = '0;
        if (!rx_s) begin
          state_n = START;
          idx_n   = '0;
          par_n   = 1'b0;
        end else begin
          state_n = IDLE;
        end
      end
      START: begin
        if (cnt == CNT_HALF) begin
          cnt_n = '0;
          if (rx_s) begin
            state_n = IDLE;
          end else begin
            state_n = DATA;
            idx_n   = '0;
          end
        end else begin
          state_n = START;
        end
      end
      DATA: begin
        if (cnt == CNT_BIT) begin
          cnt_n = '0;
          par_n = par ^ rx_s;
          for (int i = 0; i < DATA_W; i++) begin
            if (idx == IW'(i)) begin
              shreg_n[i] = rx_s;
            end else begin
              shreg_n[i] = shreg[i];
            end
          end
          if (idx == IDX_LAST) begin
            state_n = PARITY;
          end else begin
            idx_n = idx + 1'b1;
          end
        end else begin
          state_n = DATA;
        end
      end
      PARITY: begin
        if (cnt == CNT_BIT) begin
          cnt_n   = '0;
          p_bit_n = rx_s;
          state_n = STOP;
        end else begin
          state_n = PARITY;
        end
      end
      STOP: begin
        if (cnt == CNT_BIT) begin
          cnt_n  = '0;
          data_n = shreg;
          // A low stop bit is a framing error; parity is then meaningless
          if (!rx_s) begin
            frame_err_n = 1'b1;
            state_n     = WAIT_IDLE;
          end else if (p_bit != par) begin
            parity_err_n = 1'b1;
            state_n      = IDLE;
          end else begin
            valid_n = 1'b1;
            state_n = IDLE;
          end
        end else begin
          state_n = STOP;
        end
      end
      WAIT_IDLE: begin
        cnt_n = '0;
        if (rx_s) begin
          state_n = IDLE;
        end else begin
          state_n = WAIT_IDLE;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase

    busy_n = (state_n != IDLE);
  end

endmodule

// File: tb/tb_parity_frame_rx.sv
// Self-checking bench for parity_frame_rx: directed scenarios plus random frames,
// scored against an expectation queue built from the frame-format rules.
module tb_parity_frame_rx;

  localparam int DW  = 8;
  localparam int CPB = 4;
  localparam int H   = CPB / 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          rx;
  logic [DW-1:0] data;
  logic          valid, parity_err, frame_err, busy;

  parity_frame_rx #(.DATA_W(DW), .CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst(rst), .rx(rx), .data(data), .valid(valid),
    .parity_err(parity_err), .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          kind;   // 0 good, 1 parity error, 2 framing error
    logic [DW-1:0] d;
  } exp_t;

  int          errors = 0;
  int          checks = 0;
  int unsigned cyc = 0;
  exp_t        exp_q[$];
  int unsigned pulse_cyc[$];
  logic [DW-1:0] model_data = '0;
  int          mon_kind;
  exp_t        mon_exp;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int expect_kind(input logic [DW-1:0] d, input logic p, input logic stop);
    if (!stop) return 2;
    if (int'(p) != ($countones(d) % 2)) return 1;
    return 0;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic b);
    rx = b;
    tick(CPB);
  endtask

  task automatic send_frame(input logic [DW-1:0] d, input logic p, input logic stop);
    exp_t e;
    e.kind = expect_kind(d, p, stop);
    e.d    = d;
    exp_q.push_back(e);
    drive_bit(1'b0);
    for (int i = 0; i < DW; i++) drive_bit(d[i]);
    drive_bit(p);
    drive_bit(stop);
  endtask

  // Scoreboard: every status pulse must match the oldest outstanding frame
  always @(negedge clk) begin
    if (!rst && (valid || parity_err || frame_err)) begin
      check_eq("onehot", $countones({valid, parity_err, frame_err}), 1);
      mon_kind = valid ? 0 : (parity_err ? 1 : 2);
      if (valid) pulse_cyc.push_back(cyc);
      check_eq("pulse_expected", (exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        mon_exp = exp_q.pop_front();
        check_eq("kind", mon_kind, mon_exp.kind);
        check_eq("data", data, mon_exp.d);
        model_data = mon_exp.d;
      end
    end
  end

  initial begin
    logic [DW-1:0] w;
    logic          p, s;

    rst = 1'b1;
    rx  = 1'b1;
    tick(3);
    check_eq("rst_data", data, 0);
    check_eq("rst_valid", valid, 0);
    check_eq("rst_perr", parity_err, 0);
    check_eq("rst_ferr", frame_err, 0);
    check_eq("rst_busy", busy, 0);
    rst = 1'b0;
    tick(5);

    send_frame(8'hA5, 1'b0, 1'b1);
    tick(4);
    check_eq("good_busy_low", busy, 0);
    check_eq("good_drained", exp_q.size(), 0);

    send_frame(8'h07, 1'b0, 1'b1);
    tick(4);
    check_eq("perr_drained", exp_q.size(), 0);

    send_frame(8'h3C, 1'b0, 1'b0);
    tick(20);
    check_eq("ferr_busy_high", busy, 1);
    check_eq("ferr_drained", exp_q.size(), 0);
    rx = 1'b1;
    tick(3);
    check_eq("ferr_busy_drop", busy, 0);
    send_frame(8'h81, 1'b0, 1'b1);
    tick(4);

    rx = 1'b0;
    tick(1);
    rx = 1'b1;
    tick(2);
    check_eq("false_busy_pulse", busy, 1);
    tick(H + 2);
    check_eq("false_busy_low", busy, 0);
    check_eq("false_data_hold", data, model_data);
    check_eq("false_no_pulse", exp_q.size(), 0);

    pulse_cyc.delete();
    send_frame(8'h55, 1'b0, 1'b1);
    send_frame(8'hFF, 1'b0, 1'b1);
    tick(4);
    check_eq("b2b_count", pulse_cyc.size(), 2);
    if (pulse_cyc.size() == 2)
      check_eq("b2b_spacing", pulse_cyc[1] - pulse_cyc[0], (DW + 3) * CPB);

    w = 8'h34;
    drive_bit(1'b0);
    for (int i = 0; i < 3; i++) drive_bit(w[i]);
    rx = w[3];
    tick(2);
    rst = 1'b1;
    #1;
    check_eq("mid_rst_data", data, 0);
    check_eq("mid_rst_pulses", {valid, parity_err, frame_err}, 0);
    check_eq("mid_rst_busy", busy, 0);
    model_data = '0;
    rx = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(2);
    send_frame(8'h12, 1'b0, 1'b1);
    tick(4);
    check_eq("post_rst_drained", exp_q.size(), 0);

    for (int n = 0; n < 40; n++) begin
      w = DW'($urandom);
      p = 1'($urandom);
      s = ($urandom_range(0, 3) != 0);
      send_frame(w, p, s);
      if (!s) begin
        rx = 1'b1;
        tick(CPB + $urandom_range(0, 3));
      end else begin
        tick($urandom_range(0, 4));
      end
    end

    tick(10);
    check_eq("final_drained", exp_q.size(), 0);
    check_eq("final_busy", busy, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
